// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_pkg : receiver state encoding and oversampling constants. Rev 1.0
// ============================================================================
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } rx_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;
   localparam int OS_W       = $clog2(OVERSAMPLE);

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_sync_fifo : first-word-fall-through FIFO with full/empty/count.
// Rev 1.0
// ============================================================================
module uart_rx_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_en;
   logic             rd_en;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

   // A pop frees a slot in the same cycle, so a push into a full FIFO with a pop succeeds.
   assign rd_en   = pop_i & ~empty_o;
   assign wr_en   = push_i & (~full_o | rd_en);

   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : 16x-oversampled UART receiver feeding an error-tagged FWFT FIFO.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits. Rev 1.0
// ============================================================================
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          CLOCK,
   input  logic                          reset,
   input  logic                          Rx_raw,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic                          par_odd,
   input  logic                          Rd_en,
   input  logic                          clr_ovrflw,
   output logic [DATA_W-1:0]             out,
   output logic                          d_valid,
   output logic                          SFE,
   output logic                          par_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef UART_RX_PARITY_EN
   localparam int ENTRY_W = DATA_W + 2;
`else
   localparam int ENTRY_W = DATA_W + 1;
`endif

   rx_state_e          state_q;
   logic               sync1_q, sync2_q, sync3_q;
   logic [DIV_W-1:0]   cnt_q;
   logic [DIV_W-1:0]   div_m1;
   logic [OS_W-1:0]    os_q;
   logic [3:0]         bit_q;
   logic [DATA_W-1:0]  shreg_q;
   logic               push_q;
   logic               push_sfe_q;
   logic               overflow_q;
   logic               rx_s, fall, tick, mid;
   logic [ENTRY_W-1:0] push_entry, head;
   logic               fifo_empty, fifo_full, drop;

   assign rx_s   = sync2_q;
   assign fall   = sync3_q & ~sync2_q;
   assign div_m1 = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
   assign tick   = (state_q != IDLE) && (cnt_q == '0);
   assign mid    = tick && (os_q == OS_W'(MID_SAMPLE - 1));

   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
      end else begin
         sync1_q <= Rx_raw;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (state_q == IDLE) begin
         if (fall) cnt_q <= div_m1;
      end else if (cnt_q == '0) begin
         cnt_q <= div_m1;
      end else begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit_q;
   logic push_perr_q;
   assign push_entry = {push_perr_q, push_sfe_q, shreg_q};
`else
   logic unused_par_odd;
   assign unused_par_odd = par_odd;
   assign push_entry     = {push_sfe_q, shreg_q};
`endif

   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         os_q       <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         push_q     <= 1'b0;
         push_sfe_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit_q   <= 1'b0;
         push_perr_q <= 1'b0;
`endif
      end else begin
         push_q <= 1'b0;
         if (tick) os_q <= os_q + OS_W'(1);
         case (state_q)
            IDLE: begin
               if (fall) begin
                  state_q <= START;
                  os_q    <= '0;
               end
            end
            START: begin
               if (mid) begin
                  state_q <= rx_s ? IDLE : DATA;
                  bit_q   <= '0;
               end
            end
            DATA: begin
               if (mid) begin
                  shreg_q <= {rx_s, shreg_q[DATA_W-1:1]};
                  bit_q   <= bit_q + 4'd1;
                  if (bit_q == 4'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (mid) begin
                  par_bit_q <= rx_s;
                  state_q   <= STOP;
               end
            end
`endif
            STOP: begin
               if (mid) begin
                  push_q     <= 1'b1;
                  push_sfe_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                  push_perr_q <= ((^shreg_q) ^ par_bit_q) != par_odd;
`endif
                  // A low stop bit may be a break; wait for the line to recover before rearming.
                  state_q <= rx_s ? IDLE : WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               if (rx_s) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   uart_rx_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLOCK),
      .rst_ni  (reset),
      .push_i  (push_q),
      .data_i  (push_entry),
      .pop_i   (Rd_en),
      .data_o  (head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   assign drop = push_q & fifo_full & ~Rd_en;

   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clr_ovrflw) begin
         overflow_q <= 1'b0;
      end
   end

   assign out      = head[DATA_W-1:0];
   assign SFE      = head[DATA_W];
   assign d_valid  = ~fifo_empty;
   assign overflow = overflow_q;
`ifdef UART_RX_PARITY_EN
   assign par_err  = head[DATA_W+1];
`else
   assign par_err  = 1'b0;
`endif

endmodule
`default_nettype wire
